// File: rtl/keypad_decoder.sv
// Keypad decoder: assembles full column sweeps from synchronized active-low rows and debounces
// single-key presses and releases. Define KEYPAD_ASCII_EN to add the key_ascii output.
module keypad_decoder #(
    parameter int unsigned DEBOUNCE_SCANS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] R,
    input  logic [1:0] col_index,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_release,
    output logic       key_pressed,
    output logic       key_multi
`ifdef KEYPAD_ASCII_EN
    ,
    output logic [7:0] key_ascii
`endif
);
    localparam logic [3:0] DebScans = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {StIdle, StConfirm, StPressed, StRelConfirm} state_e;

    logic [3:0]  rows_meta_q;
    logic [3:0]  rows_s;
    logic [1:0]  col_q;
    logic [15:0] map_q;
    logic [15:0] frozen_q;
    logic [3:0]  seen_q;
    logic        sweep_done_q;
    logic        col_change;
    logic [15:0] map_next;

    assign col_change = col_index != col_q;

    // Map with the column being left folded in.
    always_comb begin
        map_next = map_q;
        for (int r = 0; r < 4; r++) begin
            map_next[r*4 + int'(col_q)] = ~rows_s[r];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rows_meta_q  <= 4'hF;
            rows_s       <= 4'hF;
            col_q        <= 2'd0;
            map_q        <= 16'd0;
            frozen_q     <= 16'd0;
            seen_q       <= 4'd0;
            sweep_done_q <= 1'b0;
        end else begin
            rows_meta_q  <= R;
            rows_s       <= rows_meta_q;
            sweep_done_q <= 1'b0;
            if (col_change) begin
                col_q <= col_index;
                if (col_q == 2'd3) begin
                    // Leaving the last column ends the sweep; partial sweeps are discarded.
                    seen_q <= 4'd0;
                    map_q  <= 16'd0;
                    if (seen_q == 4'b0111) begin
                        frozen_q     <= map_next;
                        sweep_done_q <= 1'b1;
                    end
                end else begin
                    map_q         <= map_next;
                    seen_q[col_q] <= 1'b1;
                end
            end
        end
    end

    logic [4:0] ones;
    logic [3:0] cand_idx;
    logic       is_empty;
    logic       is_single;
    logic       is_multi;

    always_comb begin
        ones     = 5'd0;
        cand_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (frozen_q[i]) begin
                ones     = ones + 5'd1;
                cand_idx = 4'(i);
            end
        end
    end

    assign is_empty  = ones == 5'd0;
    assign is_single = ones == 5'd1;
    assign is_multi  = ones >= 5'd2;

`ifdef KEYPAD_ASCII_EN
    function automatic logic [7:0] to_ascii(input logic [3:0] code);
        logic [7:0] a;
        case (code)
            4'd0:  a = 8'h31;
            4'd1:  a = 8'h32;
            4'd2:  a = 8'h33;
            4'd3:  a = 8'h41;
            4'd4:  a = 8'h34;
            4'd5:  a = 8'h35;
            4'd6:  a = 8'h36;
            4'd7:  a = 8'h42;
            4'd8:  a = 8'h37;
            4'd9:  a = 8'h38;
            4'd10: a = 8'h39;
            4'd11: a = 8'h43;
            4'd12: a = 8'h2A;
            4'd13: a = 8'h30;
            4'd14: a = 8'h23;
            default: a = 8'h44;
        endcase
        return a;
    endfunction
`endif

    state_e     state_q;
    logic [3:0] cand_q;
    logic [3:0] cnt_q;
    logic [3:0] cnt_inc;
    logic       press_now;
    logic       release_now;

    assign cnt_inc = cnt_q + 4'd1;

    assign press_now = sweep_done_q && is_single &&
        ((state_q == StIdle && DebScans == 4'd1) ||
         (state_q == StConfirm && cand_idx == cand_q && cnt_inc == DebScans));

    assign release_now = sweep_done_q && is_empty &&
        ((state_q == StPressed && DebScans == 4'd1) ||
         (state_q == StRelConfirm && cnt_inc == DebScans));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cand_q      <= 4'd0;
            cnt_q       <= 4'd0;
            key_code    <= 4'd0;
            key_valid   <= 1'b0;
            key_release <= 1'b0;
            key_pressed <= 1'b0;
            key_multi   <= 1'b0;
`ifdef KEYPAD_ASCII_EN
            key_ascii   <= 8'd0;
`endif
        end else begin
            key_valid   <= press_now;
            key_release <= release_now;
            if (press_now) begin
                key_code    <= cand_idx;
                key_pressed <= 1'b1;
`ifdef KEYPAD_ASCII_EN
                key_ascii   <= to_ascii(cand_idx);
`endif
            end
            if (release_now) begin
                key_pressed <= 1'b0;
            end
            if (sweep_done_q) begin
                key_multi <= is_multi;
                case (state_q)
                    StIdle: begin
                        if (is_single) begin
                            cand_q  <= cand_idx;
                            cnt_q   <= 4'd1;
                            state_q <= press_now ? StPressed : StConfirm;
                        end
                    end
                    StConfirm: begin
                        if (is_single && cand_idx == cand_q) begin
                            cnt_q <= cnt_inc;
                            if (press_now) state_q <= StPressed;
                        end else if (is_single) begin
                            cand_q <= cand_idx;
                            cnt_q  <= 4'd1;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                    StPressed: begin
                        if (is_empty) begin
                            cnt_q   <= 4'd1;
                            state_q <= release_now ? StIdle : StRelConfirm;
                        end
                    end
                    StRelConfirm: begin
                        if (is_empty) begin
                            cnt_q <= cnt_inc;
                            if (release_now) state_q <= StIdle;
                        end else begin
                            state_q <= StPressed;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_decoder.sv
// Bench for keypad_decoder: directed scenarios plus random sweeps checked against a
// sweep-history model (press = last N sweeps the same single key, release = last N empty).
module tb_keypad_decoder;
    localparam int unsigned DEB = 3;
    localparam int PERIOD = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] R;
    logic [1:0] col_index;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_release;
    logic       key_pressed;
    logic       key_multi;
`ifdef KEYPAD_ASCII_EN
    logic [7:0] key_ascii;
`endif

    keypad_decoder #(.DEBOUNCE_SCANS(DEB)) dut (
        .clk         (clk),
        .rst         (rst),
        .R           (R),
        .col_index   (col_index),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_release (key_release),
        .key_pressed (key_pressed),
        .key_multi   (key_multi)
`ifdef KEYPAD_ASCII_EN
        ,
        .key_ascii   (key_ascii)
`endif
    );

    always #(PERIOD / 2) clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse monitor
    int     valid_cnt = 0;
    int     rel_cnt = 0;
    longint valid_t = 0;

    always @(negedge clk) begin
        if (key_valid) begin
            valid_cnt++;
            valid_t = $time;
        end
        if (key_release) rel_cnt++;
        if (key_valid || key_release)
            check_eq("valid_release_excl", 32'(key_valid & key_release), 32'd0);
    end

    // Reference model over the history of evaluated sweeps: -1 empty, 16 multi, else key index
    int hist[$];
    bit m_pressed = 0;
    int m_code = 0;
    bit m_multi = 0;

    function automatic logic [7:0] ascii_of(input int code);
        string tbl = "123A456B789C*0#D";
        return tbl[code];
    endfunction

    function automatic logic [3:0] rows_for(input logic [15:0] keys, input int c);
        logic [3:0] rows;
        for (int r = 0; r < 4; r++) rows[r] = ~keys[r*4 + c];
        return rows;
    endfunction

    task automatic model_sweep(input logic [15:0] keys, output bit ev, output bit er);
        int  n;
        int  v;
        bit  same;
        ev = 0;
        er = 0;
        n = $countones(keys);
        v = (n == 0) ? -1 : 16;
        if (n == 1) begin
            for (int i = 0; i < 16; i++) if (keys[i]) v = i;
        end
        hist.push_back(v);
        if (hist.size() > DEB) void'(hist.pop_front());
        if (hist.size() == DEB) begin
            same = 1;
            foreach (hist[i]) if (hist[i] != hist[0]) same = 0;
            if (!m_pressed && same && hist[0] >= 0 && hist[0] < 16) begin
                ev = 1;
                m_pressed = 1;
                m_code = hist[0];
            end else if (m_pressed && same && hist[0] == -1) begin
                er = 1;
                m_pressed = 0;
            end
        end
        m_multi = (n >= 2);
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "_code"}, 32'(key_code), 32'(m_code));
        check_eq({tag, "_pressed"}, 32'(key_pressed), 32'(m_pressed));
        check_eq({tag, "_multi"}, 32'(key_multi), 32'(m_multi));
`ifdef KEYPAD_ASCII_EN
        check_eq({tag, "_ascii"}, 32'(key_ascii), (m_code == 0 && !m_pressed && valid_cnt == 0)
                 ? 32'd0 : 32'(ascii_of(m_code)));
`endif
    endtask

    // One full sweep 0..3, then the 3->0 change that completes it.
    task automatic do_sweep(input logic [15:0] keys, input string tag);
        bit     ev;
        bit     er;
        int     v0;
        int     r0;
        longint t0;
        v0 = valid_cnt;
        r0 = rel_cnt;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            col_index = 2'(c);
            R = rows_for(keys, c);
            repeat (7) @(negedge clk);
        end
        @(negedge clk);
        col_index = 2'd0;
        R = 4'hF;
        t0 = $time;
        repeat (4) @(negedge clk);
        model_sweep(keys, ev, er);
        check_eq({tag, "_valid_pulses"}, 32'(valid_cnt - v0), 32'(ev));
        check_eq({tag, "_release_pulses"}, 32'(rel_cnt - r0), 32'(er));
        if (ev) check_eq({tag, "_valid_latency"}, 32'(valid_t - t0), 32'(2 * PERIOD));
        check_outputs(tag);
    endtask

    localparam logic [15:0] K6 = 16'h0040;
    localparam logic [15:0] K0 = 16'h0001;
    localparam logic [15:0] K0K5 = 16'h0021;

    initial begin
        int     v0;
        int     r0;
        int     a;
        int     b;
        int     sel;
        logic [15:0] cur;

        rst = 1'b1;
        R = 4'hF;
        col_index = 2'd0;
        repeat (3) @(negedge clk);
        check_eq("reset_code", 32'(key_code), 32'd0);
        check_eq("reset_valid", 32'(key_valid), 32'd0);
        check_eq("reset_release", 32'(key_release), 32'd0);
        check_eq("reset_pressed", 32'(key_pressed), 32'd0);
        check_eq("reset_multi", 32'(key_multi), 32'd0);
`ifdef KEYPAD_ASCII_EN
        check_eq("reset_ascii", 32'(key_ascii), 32'd0);
`endif
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Key 6 held for three sweeps confirms a press
        repeat (3) do_sweep(K6, "press6");
        check_eq("press6_final_code", 32'(key_code), 32'd6);
        check_eq("press6_total_valid", 32'(valid_cnt), 32'd1);

        // Two empties then key 6 again: no release
        repeat (2) do_sweep(16'h0, "gap_empty");
        do_sweep(K6, "gap_back");
        check_eq("gap_still_pressed", 32'(key_pressed), 32'd1);

        // Three empties release, code held
        repeat (3) do_sweep(16'h0, "release6");
        check_eq("release6_total", 32'(rel_cnt), 32'd1);
        check_eq("release6_code_held", 32'(key_code), 32'd6);

        // Bouncing key 0
        v0 = valid_cnt;
        for (int i = 0; i < 6; i++) do_sweep((i % 2 == 0) ? K0 : 16'h0, "bounce");
        check_eq("bounce_no_valid", 32'(valid_cnt - v0), 32'd0);

        // Keys 0 and 5 together
        v0 = valid_cnt;
        repeat (5) do_sweep(K0K5, "multi");
        check_eq("multi_level", 32'(key_multi), 32'd1);
        check_eq("multi_no_valid", 32'(valid_cnt - v0), 32'd0);
        do_sweep(16'h0, "multi_clear");

        // Reset during a press
        repeat (3) do_sweep(K6, "prereset");
        r0 = rel_cnt;
        v0 = valid_cnt;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("midrst_pressed", 32'(key_pressed), 32'd0);
        check_eq("midrst_code", 32'(key_code), 32'd0);
        check_eq("midrst_multi", 32'(key_multi), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        hist.delete();
        m_pressed = 0;
        m_code = 0;
        m_multi = 0;
        check_eq("midrst_no_release", 32'(rel_cnt - r0), 32'd0);
        // Partial sweep starting at column 2 must not evaluate
        for (int c = 2; c < 4; c++) begin
            @(negedge clk);
            col_index = 2'(c);
            R = rows_for(K6, c);
            repeat (7) @(negedge clk);
        end
        @(negedge clk);
        col_index = 2'd0;
        R = 4'hF;
        repeat (6) @(negedge clk);
        check_eq("partial_no_valid", 32'(valid_cnt - v0), 32'd0);
        check_eq("partial_pressed", 32'(key_pressed), 32'd0);
        // First complete sweeps after reset are evaluated normally
        repeat (3) do_sweep(K6, "postrst");

        // Randomized sweeps
        cur = 16'h0;
        for (int s = 0; s < 120; s++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 50) begin
                cur = cur;
            end else if (sel < 70) begin
                cur = 16'h0;
            end else if (sel < 90) begin
                cur = 16'd1 << $urandom_range(0, 15);
            end else begin
                a = int'($urandom_range(0, 15));
                b = (a + 1 + int'($urandom_range(0, 14))) % 16;
                cur = (16'd1 << a) | (16'd1 << b);
            end
            do_sweep(cur, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
